// File: rtl/keypad_scan_controller_pkg.sv
// Shared types and defaults for the 3x3 keypad scanner: scan FSM states,
// frame classifications and the default matrix geometry.
package keypad_scan_controller_pkg;

  // Default geometry of the mole keypad
  localparam int DEF_ROWS  = 3;
  localparam int DEF_COLS  = 3;
  localparam int DEF_KEY_W = 4;

  // Scan sequencer states
  typedef enum logic [1:0] {
    ST_GAP    = 2'd0,
    ST_DRIVE  = 2'd1,
    ST_SAMPLE = 2'd2
  } scan_state_t;

  // Classification of one complete scan frame
  typedef enum logic [1:0] {
    CLS_NONE  = 2'd0,
    CLS_ONE   = 2'd1,
    CLS_MULTI = 2'd2
  } frame_class_t;

  // Counter width able to hold values 0..max_val
  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/keypad_scan_controller_if.sv
// Keypad pins plus the key report handshake. The scanner is the master
// (drives rows and reports), the game logic / keypad side is the slave.
interface keypad_scan_controller_if
  import keypad_scan_controller_pkg::*;
#(
  parameter int ROWS  = DEF_ROWS,
  parameter int COLS  = DEF_COLS,
  parameter int KEY_W = DEF_KEY_W
) ();

  logic [COLS-1:0]  column;     // active-low, asynchronous to clk
  logic [ROWS-1:0]  row;        // active-low, at most one bit low
  logic [KEY_W-1:0] key_code;
  logic             key_valid;
  logic             key_ack;
  logic             key_held;
  logic             overrun;

  modport master (
    input  column, key_ack,
    output row, key_code, key_valid, key_held, overrun
  );

  modport slave (
    output column, key_ack,
    input  row, key_code, key_valid, key_held, overrun
  );

endinterface

// File: rtl/keypad_scan_controller_sync2.sv
// Two-flop synchronizer for a bus of independent, slowly changing inputs.
// Both stages preset to ones so an idle (pulled-up) keypad reads as released.
module keypad_scan_controller_sync2
  import keypad_scan_controller_pkg::*;
#(
  parameter int WIDTH = DEF_COLS
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  // Metastability stage followed by the stable output stage
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_meta <= '1;
      r_sync <= '1;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/keypad_scan_controller.sv
// Keypad scan controller: walks a low level across the rows, snapshots the
// synchronized columns per row, classifies each full frame (none / one key /
// several keys), debounces over whole frames and reports one key code per
// accepted press through a valid/ack handshake.
module keypad_scan_controller
  import keypad_scan_controller_pkg::*;
#(
  parameter int ROWS            = DEF_ROWS,
  parameter int COLS            = DEF_COLS,
  parameter int SETTLE_CYCLES   = 4,
  parameter int DEBOUNCE_FRAMES = 3,
  parameter int KEY_W           = DEF_KEY_W
) (
  input logic                     clk,
  input logic                     reset,
  keypad_scan_controller_if.master bus
);

  localparam int RIDX_W = cnt_width(ROWS - 1);
  localparam int SCNT_W = cnt_width(SETTLE_CYCLES - 1);
  localparam int DCNT_W = cnt_width(DEBOUNCE_FRAMES);
  localparam int NKEYS  = ROWS * COLS;

  // Synchronized columns
  logic [COLS-1:0]   w_col_sync;

  // Scan sequencer
  scan_state_t       r_state;
  scan_state_t       w_state_next;
  logic [RIDX_W-1:0] r_ridx;
  logic [RIDX_W-1:0] w_ridx_next;
  logic [SCNT_W-1:0] r_settle;
  logic [SCNT_W-1:0] w_settle_next;
  logic [ROWS-1:0]   r_row;
  logic [ROWS-1:0]   w_row_next;

  // Frame capture
  logic [COLS-1:0]   r_snapshot [ROWS];
  logic [NKEYS-1:0]  w_lows;
  logic              r_frame_ok;

  // Classification and debounce
  frame_class_t      w_class;
  logic [KEY_W-1:0]  w_key;
  frame_class_t      r_prev_class;
  logic [KEY_W-1:0]  r_prev_key;
  logic [DCNT_W-1:0] r_stable;
  logic [DCNT_W-1:0] w_stable_next;
  logic              w_same;
  logic              w_reach;
  logic              w_eval;

  // Report outputs
  logic [KEY_W-1:0]  r_key_code;
  logic [KEY_W-1:0]  w_key_code_next;
  logic              r_key_valid;
  logic              w_key_valid_next;
  logic              r_key_held;
  logic              w_key_held_next;
  logic              r_overrun;
  logic              w_overrun_next;

  keypad_scan_controller_sync2 #(
    .WIDTH (COLS)
  ) u_col_sync (
    .clk   (clk),
    .reset (reset),
    .i_d   (bus.column),
    .o_q   (w_col_sync)
  );

  // ------------------------------------------------------------------
  // Scan sequencer
  // ------------------------------------------------------------------

  // Next-state logic: GAP -> (DRIVE x SETTLE_CYCLES -> SAMPLE) per row -> GAP
  always_comb begin
    w_state_next  = r_state;
    w_ridx_next   = r_ridx;
    w_settle_next = r_settle;
    case (r_state)
      ST_GAP: begin
        w_ridx_next   = '0;
        w_settle_next = '0;
        w_state_next  = ST_DRIVE;
      end
      ST_DRIVE: begin
        if (r_settle == SCNT_W'(SETTLE_CYCLES - 1)) begin
          w_settle_next = '0;
          w_state_next  = ST_SAMPLE;
        end else begin
          w_settle_next = r_settle + 1'b1;
        end
      end
      ST_SAMPLE: begin
        if (r_ridx == RIDX_W'(ROWS - 1)) begin
          w_state_next = ST_GAP;
        end else begin
          w_ridx_next  = r_ridx + 1'b1;
          w_state_next = ST_DRIVE;
        end
      end
      default: begin
        w_state_next = ST_GAP;
      end
    endcase
  end

  // Row drive decoded from the upcoming state so the pins come straight
  // off a flop and only ever change on a clock edge
  always_comb begin
    w_row_next = '1;
    if (w_state_next != ST_GAP) begin
      w_row_next = ~(ROWS'(1) << w_ridx_next);
    end
  end

  // Sequencer state register and registered row drive
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= ST_GAP;
      r_ridx   <= '0;
      r_settle <= '0;
      r_row    <= '1;
    end else begin
      r_state  <= w_state_next;
      r_ridx   <= w_ridx_next;
      r_settle <= w_settle_next;
      r_row    <= w_row_next;
    end
  end

  // ------------------------------------------------------------------
  // Frame capture
  // ------------------------------------------------------------------

  // Capture the settled columns of the driven row; frame_ok marks that a
  // complete frame has been gathered since reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < ROWS; r++) begin
        r_snapshot[r] <= '1;
      end
      r_frame_ok <= 1'b0;
    end else begin
      if (r_state == ST_SAMPLE) begin
        r_snapshot[r_ridx] <= w_col_sync;
      end
      if (r_state == ST_GAP) begin
        r_frame_ok <= 1'b1;
      end
    end
  end

  // Flatten the frame into one active-high vector indexed by key number
  for (genvar gi = 0; gi < ROWS; gi++) begin : g_flat
    assign w_lows[gi*COLS +: COLS] = ~r_snapshot[gi];
  end

  // Classify the frame: no key, exactly one key (with its code), or several
  // keys, which is treated as ambiguous and never reported
  always_comb begin
    w_class = CLS_NONE;
    w_key   = '0;
    for (int k = 0; k < NKEYS; k++) begin
      if (w_lows[k]) begin
        if (w_class == CLS_NONE) begin
          w_class = CLS_ONE;
          w_key   = KEY_W'(k);
        end else begin
          w_class = CLS_MULTI;
        end
      end
    end
  end

  // ------------------------------------------------------------------
  // Debounce across frames
  // ------------------------------------------------------------------

  assign w_eval = (r_state == ST_GAP) && r_frame_ok;
  assign w_same = (w_class == r_prev_class) &&
                  ((w_class != CLS_ONE) || (w_key == r_prev_key));

  // Run-length of identical classifications; "reach" fires only on the
  // frame where the run first becomes long enough, not while saturated
  always_comb begin
    w_stable_next = DCNT_W'(1);
    if (w_same) begin
      w_stable_next = (r_stable == DCNT_W'(DEBOUNCE_FRAMES)) ? r_stable : r_stable + 1'b1;
    end
    w_reach = (w_stable_next == DCNT_W'(DEBOUNCE_FRAMES)) &&
              !(w_same && (r_stable == DCNT_W'(DEBOUNCE_FRAMES)));
  end

  // Debounce history, updated once per evaluated frame
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stable     <= '0;
      r_prev_class <= CLS_NONE;
      r_prev_key   <= '0;
    end else if (w_eval) begin
      r_stable <= w_stable_next;
      if (!w_same) begin
        r_prev_class <= w_class;
        r_prev_key   <= w_key;
      end
    end
  end

  // ------------------------------------------------------------------
  // Report and handshake
  // ------------------------------------------------------------------

  // Press/release acceptance and valid/ack; a press accepted in the same
  // cycle as an ack replaces the acknowledged report instead of overrunning
  always_comb begin
    w_key_code_next  = r_key_code;
    w_key_valid_next = r_key_valid;
    w_key_held_next  = r_key_held;
    w_overrun_next   = r_overrun;
    if (r_key_valid && bus.key_ack) begin
      w_key_valid_next = 1'b0;
    end
    if (w_eval && w_reach) begin
      if (w_class == CLS_NONE) begin
        w_key_held_next = 1'b0;
      end else if ((w_class == CLS_ONE) && !r_key_held) begin
        w_key_held_next = 1'b1;
        if (!r_key_valid || bus.key_ack) begin
          w_key_code_next  = w_key;
          w_key_valid_next = 1'b1;
        end else begin
          w_overrun_next = 1'b1;
        end
      end
    end
  end

  // Report registers; overrun is sticky until reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_key_code  <= '0;
      r_key_valid <= 1'b0;
      r_key_held  <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_key_code  <= w_key_code_next;
      r_key_valid <= w_key_valid_next;
      r_key_held  <= w_key_held_next;
      r_overrun   <= w_overrun_next;
    end
  end

  assign bus.row       = r_row;
  assign bus.key_code  = r_key_code;
  assign bus.key_valid = r_key_valid;
  assign bus.key_held  = r_key_held;
  assign bus.overrun   = r_overrun;

endmodule
